// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: CSR addresses, cause codes, mstatus bits and FSM encodings for csr_trap_ctrl
package csr_trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000000B;
  localparam int MIE  = 3;
  localparam int MPIE = 7;
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_MEPC    = 3'd1;
  localparam logic [2:0] S_WR_MCAUSE  = 3'd2;
  localparam logic [2:0] S_WR_MTVAL   = 3'd3;
  localparam logic [2:0] S_WR_MSTATUS = 3'd4;
  localparam logic [2:0] S_MRET_WR    = 3'd5;
  localparam logic [2:0] S_JUMP       = 3'd6;
  typedef struct packed {
    logic        en;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MPIE] = s[MIE];
    r[MIE] = 1'b0;
    return r;
  endfunction
  function automatic logic [31:0] ret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MIE] = s[MPIE];
    r[MPIE] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: execute-stage events, live CSRs, core write request, CSR write port and redirect
interface csr_trap_ctrl_if;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        int_req;
  logic        glb_int_en;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic        core_wren;
  logic [11:0] core_wraddr;
  logic [31:0] core_wrdata;
  logic        wren;
  logic [11:0] wraddr;
  logic [31:0] wrdata;
  logic        hold_req;
  logic        jump_en;
  logic [31:0] jump_addr;
  modport master(
    output inst_valid, inst_addr, ecall, ebreak, mret, int_req, glb_int_en,
    output csr_mtvec, csr_mepc, csr_mstatus, core_wren, core_wraddr, core_wrdata,
    input  wren, wraddr, wrdata, hold_req, jump_en, jump_addr
  );
  modport slave(
    input  inst_valid, inst_addr, ecall, ebreak, mret, int_req, glb_int_en,
    input  csr_mtvec, csr_mepc, csr_mstatus, core_wren, core_wraddr, core_wrdata,
    output wren, wraddr, wrdata, hold_req, jump_en, jump_addr
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: trap/mret sequencer owning the CSR write port; TRAP_MTVAL_EN adds an mtval write step
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RST_PC = 32'h0
) (
  input logic            clk,
  input logic            rst,
  csr_trap_ctrl_if.slave bus
);
  logic [2:0]  state, nxt;
  logic [31:0] epc, cause;
  logic        ret;
  logic        ev_ecall, ev_ebreak, ev_mret, ev_int, trap, idle, jump;
  csr_wr_t     w;
  assign ev_ecall  = bus.inst_valid & bus.ecall;
  assign ev_ebreak = bus.inst_valid & bus.ebreak;
  assign ev_mret   = bus.inst_valid & bus.mret;
  assign ev_int    = bus.inst_valid & bus.int_req & bus.glb_int_en;
  assign trap      = ev_ecall | ev_ebreak | ev_int;
  assign idle      = state == S_IDLE;
  assign jump      = state == S_JUMP;
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:                  nxt = trap ? S_WR_MEPC : ev_mret ? S_MRET_WR : S_IDLE;
      S_WR_MEPC:               nxt = S_WR_MCAUSE;
`ifdef TRAP_MTVAL_EN
      S_WR_MCAUSE:             nxt = S_WR_MTVAL;
      S_WR_MTVAL:              nxt = S_WR_MSTATUS;
`else
      S_WR_MCAUSE:             nxt = S_WR_MSTATUS;
`endif
      S_WR_MSTATUS, S_MRET_WR: nxt = S_JUMP;
      default:                 nxt = S_IDLE;
    endcase
  end
  // An event in IDLE takes the port away from the core in the same cycle
  always_comb begin
    w = '0;
    case (state)
      S_IDLE:       w = (trap | ev_mret) ? '0 : {bus.core_wren, bus.core_wraddr, bus.core_wrdata};
      S_WR_MEPC:    w = {1'b1, CSR_MEPC, epc & ~32'h3};
      S_WR_MCAUSE:  w = {1'b1, CSR_MCAUSE, cause};
`ifdef TRAP_MTVAL_EN
      S_WR_MTVAL:   w = {1'b1, CSR_MTVAL, (cause == CAUSE_EBREAK) ? epc : 32'h0};
`endif
      S_WR_MSTATUS: w = {1'b1, CSR_MSTATUS, trap_mstatus(bus.csr_mstatus)};
      S_MRET_WR:    w = {1'b1, CSR_MSTATUS, ret_mstatus(bus.csr_mstatus)};
      default:      w = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      epc   <= '0;
      cause <= '0;
      ret   <= 1'b0;
    end else begin
      state <= nxt;
      if (idle && trap) begin
        epc   <= bus.inst_addr;
        cause <= ev_ecall ? CAUSE_ECALL : ev_ebreak ? CAUSE_EBREAK : CAUSE_EXT_INT;
        ret   <= 1'b0;
      end else if (idle && ev_mret) begin
        ret   <= 1'b1;
      end
    end
  end
  assign bus.wren      = !rst & w.en;
  assign bus.wraddr    = rst ? '0 : w.addr;
  assign bus.wrdata    = rst ? '0 : w.data;
  assign bus.hold_req  = !rst & (!idle | trap | ev_mret);
  assign bus.jump_en   = !rst & jump;
  assign bus.jump_addr = (!rst && jump) ? (ret ? bus.csr_mepc : bus.csr_mtvec & ~32'h3) : RST_PC;
endmodule
